// File: rtl/io_led_switch_port.sv
// io_led_switch_port: LED output register and debounced switch input port.
// The CPU writes the LEDs and reads switch state and a sticky "switches changed" flag.
module io_led_switch_port #(
    parameter int DB_LIMIT = 500000,
    parameter int DB_W     = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        led_cs,
    input  logic        sw_cs,
    input  logic [1:0]  io_addr,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    input  logic [23:0] switch_in,
    output logic [23:0] led_out
);
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_LIMIT - 1);

    logic [23:0]     led_q, led_d;
    logic [23:0]     sync1_q, sync2_q;
    logic [23:0]     cand_q, cand_d;
    logic [23:0]     stable_q, stable_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            chg_q, chg_d;
    logic            same, accept;

    assign same   = sync2_q == cand_q;
    assign accept = same && (cnt_q == CNT_LAST);

    always_comb begin
        led_d = led_q;
        if (led_cs && io_addr == 2'd0) led_d[15:0] = io_wdata;
        if (led_cs && io_addr == 2'd1) led_d[23:16] = io_wdata[7:0];
        cand_d   = same ? cand_q : sync2_q;
        cnt_d    = !same ? '0 : accept ? cnt_q : cnt_q + 1'b1;
        stable_d = accept ? cand_q : stable_q;
        // A new accept on the same edge as a status read keeps the flag set.
        chg_d    = (accept && cand_q != stable_q) ? 1'b1 :
                   (sw_cs && io_addr == 2'd2) ? 1'b0 : chg_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            led_q    <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            chg_q    <= 1'b0;
        end else begin
            led_q    <= led_d;
            sync1_q  <= switch_in;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            chg_q    <= chg_d;
        end
    end

    always_comb begin
        io_rdata = 16'h0000;
        if (sw_cs)
            io_rdata = io_addr == 2'd0 ? stable_q[15:0] :
                       io_addr == 2'd1 ? {8'h00, stable_q[23:16]} :
                       io_addr == 2'd2 ? {15'h0, chg_q} : 16'h0000;
    end

    assign led_out = led_q;
endmodule

// File: tb/tb_io_led_switch_port.sv
// tb_io_led_switch_port: scoreboard bench for the LED/switch port with DB_LIMIT=4.
module tb_io_led_switch_port;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        led_cs = 1'b0;
    logic        sw_cs = 1'b0;
    logic [1:0]  io_addr = 2'd0;
    logic [15:0] io_wdata = 16'h0;
    logic [15:0] io_rdata;
    logic [23:0] switch_in = 24'h0;
    logic [23:0] led_out;
    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        bit          led;
        logic [23:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    io_led_switch_port #(.DB_LIMIT(4), .DB_W(3)) dut (
        .clock(clock), .reset(reset), .led_cs(led_cs), .sw_cs(sw_cs),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
        .switch_in(switch_in), .led_out(led_out)
    );

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input bit led, input logic [23:0] v);
        exp_t e;
        e.tag = tag;
        e.led = led;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic observe();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, e.led ? led_out : {8'h00, io_rdata}, e.val);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        sw_cs = 1'b1;
        io_addr = a;
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        led_cs = 1'b1;
        io_addr = a;
        io_wdata = d;
        tick();
        led_cs = 1'b0;
    endtask

    initial begin
        tick(2);
        reset = 1'b1;
        push("rst_led", 1, 24'h0);
        rd(2'd0); push("rst_rd0", 0, 24'h0); observe();
        rd(2'd2); push("rst_chg", 0, 24'h0); observe();
        sw_cs = 1'b0;

        push("led_lo", 1, 24'h00A55A); wr(2'd0, 16'hA55A); observe();
        push("led_hi", 1, 24'hC3A55A); wr(2'd1, 16'h12C3); observe();
        push("led_a2", 1, 24'hC3A55A); wr(2'd2, 16'hFFFF); observe();
        push("led_a3", 1, 24'hC3A55A); wr(2'd3, 16'hFFFF); observe();

        switch_in = 24'h00F00F;
        rd(2'd0);
        push("sw_edge5", 0, 24'h0); tick(6); observe();
        push("sw_edge6", 0, 24'h00F00F); tick(); observe();
        rd(2'd1); push("sw_rd1", 0, 24'h0); observe();
        rd(2'd2); push("chg_set", 0, 24'h1); observe();
        push("chg_clr", 0, 24'h0); tick(); observe();

        sw_cs = 1'b0;
        for (int a = 0; a < 4; a++) begin
            io_addr = 2'(a);
            #1;
            push($sformatf("gate_a%0d", a), 0, 24'h0);
            observe();
        end

        rd(2'd0);
        switch_in = 24'h00F007;
        tick(3);
        switch_in = 24'h00F00F;
        push("glitch_stable", 0, 24'h00F00F); tick(10); observe();
        rd(2'd2); push("glitch_chg", 0, 24'h0); observe();

        rd(2'd0);
        switch_in = 24'h00F007;
        push("pulse7_pre", 0, 24'h00F00F); tick(6); observe();
        push("pulse7_acc", 0, 24'h00F007); tick(); observe();
        rd(2'd2); push("pulse7_chg", 0, 24'h1); observe();
        push("pre_clr", 0, 24'h0); tick(); observe();

        sw_cs = 1'b0;
        switch_in = 24'h00F00F;
        tick(6);
        rd(2'd2); push("race_pre", 0, 24'h0); observe();
        push("race_set_wins", 0, 24'h1); tick(); observe();
        push("race_clr", 0, 24'h0); tick(); observe();
        rd(2'd0); push("race_stable", 0, 24'h00F00F); observe();
        sw_cs = 1'b0;

        wr(2'd0, 16'hFFFF);
        push("led_ff", 1, 24'hFFFFFF); wr(2'd1, 16'h00FF); observe();
        switch_in = 24'h000AAA;
        tick(5);
        reset = 1'b0;
        led_cs = 1'b1; io_addr = 2'd1; io_wdata = 16'h0055;
        tick();
        led_cs = 1'b0;
        reset = 1'b1;
        push("rst_mid_led", 1, 24'h0);
        rd(2'd0); push("rst_mid_rd0", 0, 24'h0); observe();
        rd(2'd2); push("rst_mid_chg", 0, 24'h0); observe();
        rd(2'd0);
        push("rst_discard", 0, 24'h0); tick(6); observe();
        push("rst_reaccept", 0, 24'h000AAA); tick(); observe();
        sw_cs = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
